// File: rtl/debug_fifo_port.sv
// Memory-mapped debug character port: TX/RX byte FIFOs between the mgmt bus
// and a host valid/ready byte stream, with status/control registers and a level irq.
`ifndef ADDR_DBG
`define ADDR_DBG 16'h0100
`endif
`ifndef MASK_DBG
`define MASK_DBG 16'hFFF0
`endif

module debug_fifo_port #(
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [15:0] BASE_ADDR = `ADDR_DBG,
    parameter logic [15:0] ADDR_MASK = `MASK_DBG
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fifo_tx_vld,
    output logic [7:0]  fifo_tx_dat,
    input  logic        fifo_tx_rdy,
    input  logic        fifo_rx_vld,
    input  logic [7:0]  fifo_rx_dat,
    output logic        fifo_rx_rdy,
    input  logic        mgmt_req,
    input  logic [31:0] mgmt_adr,
    output logic        mgmt_ack,
    input  logic        mgmt_rwn,
    input  logic [1:0]  mgmt_wen,
    input  logic [31:0] mgmt_txd,
    output logic        mgmt_rxe,
    output logic [31:0] mgmt_rxd,
    output logic        irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TX_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cnt;
    logic [RX_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_cnt;
    logic           tx_ovf_q, tx_ovf_d, rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic           ack_q, ack_d, rxe_q, rxe_d, irq_q, irq_d;
    logic [31:0]    rxd_q, rxd_d;
    logic           tx_full, tx_empty, rx_full, rx_empty;
    logic           hit, wr_en, rd_en, ctrl_wr, tx_push, tx_pop, rx_push, rx_pop;
    logic [1:0]     sel;
    logic           unused_bits;

    assign unused_bits = ^{mgmt_adr[31:16], mgmt_txd[31:8]};

    // Full when pointers differ only in the extra wrap bit.
    assign tx_cnt   = tx_wr_q - tx_rd_q;
    assign rx_cnt   = rx_wr_q - rx_rd_q;
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                      (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
    assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);

    assign fifo_tx_vld = !tx_empty;
    assign fifo_tx_dat = tx_mem[tx_rd_q[TX_AW-1:0]];
    assign fifo_rx_rdy = !rx_full;
    assign mgmt_ack    = ack_q;
    assign mgmt_rxe    = rxe_q;
    assign mgmt_rxd    = rxd_q;
    assign irq         = irq_q;

    always_comb begin
        hit     = mgmt_req && ((mgmt_adr[15:0] & ADDR_MASK) == BASE_ADDR);
        sel     = mgmt_adr[3:2];
        wr_en   = hit && !mgmt_rwn && (mgmt_wen != 2'b00);
        rd_en   = hit && mgmt_rwn;
        ctrl_wr = wr_en && (sel == 2'd2);
        tx_push = wr_en && (sel == 2'd0) && !tx_full;
        tx_pop  = !tx_empty && fifo_tx_rdy;
        rx_push = fifo_rx_vld && !rx_full;
        rx_pop  = rd_en && (sel == 2'd0) && !rx_empty;

        tx_wr_d  = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + 1'b1 : tx_rd_q;
        rx_wr_d  = rx_push ? rx_wr_q + 1'b1 : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + 1'b1 : rx_rd_q;
        tx_ovf_d = tx_ovf_q || (wr_en && (sel == 2'd0) && tx_full);
        rx_ie_d  = rx_ie_q;
        tx_ie_d  = tx_ie_q;

        // Flush overrides any same-cycle push/pop of that FIFO.
        if (ctrl_wr) begin
            rx_ie_d = mgmt_txd[3];
            tx_ie_d = mgmt_txd[4];
            if (mgmt_txd[0]) begin
                tx_wr_d = '0;
                tx_rd_d = '0;
            end
            if (mgmt_txd[1]) begin
                rx_wr_d = '0;
                rx_rd_d = '0;
            end
            if (mgmt_txd[2]) tx_ovf_d = 1'b0;
        end

        rxd_d = 32'h0;
        if (rd_en) begin
            case (sel)
                2'd0:    rxd_d = rx_empty ? 32'h0 : {23'h0, 1'b1, rx_mem[rx_rd_q[RX_AW-1:0]]};
                2'd1:    rxd_d = {9'h0, tx_ie_q, rx_ie_q, tx_ovf_q, rx_empty, rx_full,
                                  tx_empty, tx_full, 8'(rx_cnt), 8'(tx_cnt)};
                2'd2:    rxd_d = {27'h0, tx_ie_q, rx_ie_q, 3'b000};
                default: rxd_d = 32'h0;
            endcase
        end
        ack_d = hit;
        rxe_d = rd_en;
        irq_d = (rx_ie_q && !rx_empty) || (tx_ie_q && tx_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            tx_ovf_q <= 1'b0;
            rx_ie_q  <= 1'b0;
            tx_ie_q  <= 1'b0;
            ack_q    <= 1'b0;
            rxe_q    <= 1'b0;
            rxd_q    <= 32'h0;
            irq_q    <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ie_q  <= rx_ie_d;
            tx_ie_q  <= tx_ie_d;
            ack_q    <= ack_d;
            rxe_q    <= rxe_d;
            rxd_q    <= rxd_d;
            irq_q    <= irq_d;
        end
    end

    // Storage carries no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= mgmt_txd[7:0];
        if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= fifo_rx_dat;
`ifdef DEBUG
        if (tx_push) $write("%c", mgmt_txd[7:0]);
`endif
    end

endmodule

// File: tb/tb_debug_fifo_port.sv
// Directed bench for debug_fifo_port: register table plus FIFO, irq and reset sequences.
module tb_debug_fifo_port;
    localparam logic [31:0] A_DATA = 32'h0000_0100;
    localparam logic [31:0] A_STAT = 32'h0000_0104;
    localparam logic [31:0] A_CTRL = 32'h0000_0108;
    localparam logic [31:0] A_RSV  = 32'h0000_010C;
    localparam logic [31:0] A_MISS = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_tx_vld, fifo_tx_rdy = 1'b0;
    logic [7:0]  fifo_tx_dat, fifo_rx_dat = 8'h0;
    logic        fifo_rx_vld = 1'b0, fifo_rx_rdy;
    logic        mgmt_req = 1'b0, mgmt_rwn = 1'b0, mgmt_ack, mgmt_rxe, irq;
    logic [31:0] mgmt_adr = 32'h0, mgmt_txd = 32'h0, mgmt_rxd;
    logic [1:0]  mgmt_wen = 2'b00;

    int n_chk = 0;
    int n_fail = 0;
    logic        r_ack, r_rxe;
    logic [31:0] r_rd;

    typedef struct {
        logic        rwn;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [1:0]  wen;
        logic        exp_ack;
        logic        exp_rxe;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    debug_fifo_port dut (
        .clk(clk), .rst(rst),
        .fifo_tx_vld(fifo_tx_vld), .fifo_tx_dat(fifo_tx_dat), .fifo_tx_rdy(fifo_tx_rdy),
        .fifo_rx_vld(fifo_rx_vld), .fifo_rx_dat(fifo_rx_dat), .fifo_rx_rdy(fifo_rx_rdy),
        .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_ack(mgmt_ack), .mgmt_rwn(mgmt_rwn),
        .mgmt_wen(mgmt_wen), .mgmt_txd(mgmt_txd), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd),
        .irq(irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the response cycle.
    task automatic bus(input logic rwn, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [1:0] wen);
        mgmt_req = 1'b1;
        mgmt_rwn = rwn;
        mgmt_adr = adr;
        mgmt_txd = wd;
        mgmt_wen = wen;
        @(posedge clk); #1;
        mgmt_req = 1'b0;
        r_ack = mgmt_ack;
        r_rxe = mgmt_rxe;
        r_rd  = mgmt_rxd;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
        bus(1'b0, adr, wd, 2'b11);
        chk("write_ack", {31'h0, r_ack}, 32'h1);
    endtask

    task automatic rd(input string nm, input logic [31:0] adr, input logic [31:0] exp);
        bus(1'b1, adr, 32'h0, 2'b00);
        chk({nm, "_ack"}, {31'h0, r_ack}, 32'h1);
        chk({nm, "_rxe"}, {31'h0, r_rxe}, 32'h1);
        chk(nm, r_rd, exp);
    endtask

    task automatic host_push(input logic [7:0] b);
        fifo_rx_vld = 1'b1;
        fifo_rx_dat = b;
        @(posedge clk); #1;
        fifo_rx_vld = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, A_DATA, 32'h41, 2'b11, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, A_DATA, 32'h42, 2'b01, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, A_STAT, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0008_0002};
        tbl[3]  = '{1'b1, A_DATA, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, A_CTRL, 32'h18, 2'b11, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, A_CTRL, 32'h0, 2'b00, 1'b1, 1'b1, 32'h18};
        tbl[6]  = '{1'b1, A_STAT, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0068_0002};
        tbl[7]  = '{1'b1, A_RSV,  32'h0, 2'b00, 1'b1, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, A_RSV,  32'hFF, 2'b11, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, A_DATA, 32'h43, 2'b00, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{1'b0, A_STAT, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{1'b1, A_STAT, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0068_0002};
        tbl[12] = '{1'b1, A_MISS, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b0, A_CTRL, 32'h00, 2'b10, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 32'hABCD_0108, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0};
        tbl[15] = '{1'b1, A_STAT, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0008_0002};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_vld", {31'h0, fifo_tx_vld}, 32'h0);
        chk("rst_rx_rdy", {31'h0, fifo_rx_rdy}, 32'h1);
        chk("rst_ack", {31'h0, mgmt_ack}, 32'h0);
        chk("rst_rxe", {31'h0, mgmt_rxe}, 32'h0);
        chk("rst_rxd", mgmt_rxd, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            bus(tbl[i].rwn, tbl[i].adr, tbl[i].wd, tbl[i].wen);
            chk($sformatf("vec%0d_ack", i), {31'h0, r_ack}, {31'h0, tbl[i].exp_ack});
            chk($sformatf("vec%0d_rxe", i), {31'h0, r_rxe}, {31'h0, tbl[i].exp_rxe});
            chk($sformatf("vec%0d_rxd", i), r_rd, tbl[i].exp_rd);
        end

        // Host drains the two buffered bytes in order.
        chk("tx_head0", {23'h0, fifo_tx_vld, fifo_tx_dat}, 32'h141);
        fifo_tx_rdy = 1'b1;
        tick();
        chk("tx_head1", {23'h0, fifo_tx_vld, fifo_tx_dat}, 32'h142);
        tick();
        fifo_tx_rdy = 1'b0;
        chk("tx_drained_vld", {31'h0, fifo_tx_vld}, 32'h0);
        rd("stat_tx_empty", A_STAT, 32'h000A_0000);

        // Overflow: DEPTH+1 writes with host stalled, then drain across the wrap.
        for (int i = 0; i < 17; i++) wr(A_DATA, i);
        rd("stat_ovf", A_STAT, 32'h0019_0010);
        wr(A_CTRL, 32'h04);
        rd("stat_ovf_clr", A_STAT, 32'h0009_0010);
        fifo_tx_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_wrap%0d", i), {23'h0, fifo_tx_vld, fifo_tx_dat}, 32'h100 | i);
            tick();
        end
        fifo_tx_rdy = 1'b0;
        chk("tx_dropped_absent", {31'h0, fifo_tx_vld}, 32'h0);

        // RX single byte.
        host_push(8'h5A);
        rd("rx_5a", A_DATA, 32'h0000_015A);
        rd("rx_empty_read", A_DATA, 32'h0);

        // RX fill, backpressure, wrap order.
        for (int i = 0; i < 16; i++) host_push(8'h80 + 8'(i));
        chk("rx_full_rdy", {31'h0, fifo_rx_rdy}, 32'h0);
        rd("stat_rx_full", A_STAT, 32'h0006_1000);
        host_push(8'hFF);
        rd("rx_first", A_DATA, 32'h0000_0180);
        chk("rx_rdy_back", {31'h0, fifo_rx_rdy}, 32'h1);
        for (int i = 1; i < 16; i++) rd($sformatf("rx_order%0d", i), A_DATA, 32'h100 | (32'h80 + i));
        rd("rx_after_drain", A_DATA, 32'h0);

        // Pop request on empty FIFO in the same cycle as a host push.
        fifo_rx_vld = 1'b1;
        fifo_rx_dat = 8'h77;
        rd("rx_same_cycle", A_DATA, 32'h0);
        fifo_rx_vld = 1'b0;
        rd("rx_same_cycle_next", A_DATA, 32'h0000_0177);

        // Interrupts.
        wr(A_CTRL, 32'h08);
        host_push(8'h33);
        chk("irq_lag", {31'h0, irq}, 32'h0);
        tick();
        chk("irq_rx_set", {31'h0, irq}, 32'h1);
        rd("rx_33", A_DATA, 32'h0000_0133);
        tick();
        chk("irq_rx_clr", {31'h0, irq}, 32'h0);
        wr(A_DATA, 32'h55);
        host_push(8'h66);
        rd("stat_pre_flush", A_STAT, 32'h0020_0101);
        wr(A_CTRL, 32'h03);
        rd("stat_flushed", A_STAT, 32'h000A_0000);
        wr(A_CTRL, 32'h10);
        tick();
        chk("irq_tx_set", {31'h0, irq}, 32'h1);
        wr(A_CTRL, 32'h00);
        tick();
        chk("irq_tx_clr", {31'h0, irq}, 32'h0);

        // Reset asserted while a read is in flight.
        wr(A_DATA, 32'hAA);
        wr(A_CTRL, 32'h08);
        host_push(8'hBB);
        mgmt_req = 1'b1;
        mgmt_rwn = 1'b1;
        mgmt_adr = A_DATA;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        mgmt_req = 1'b0;
        chk("midrst_ack", {31'h0, mgmt_ack}, 32'h0);
        chk("midrst_rxe", {31'h0, mgmt_rxe}, 32'h0);
        chk("midrst_rxd", mgmt_rxd, 32'h0);
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        chk("midrst_tx_vld", {31'h0, fifo_tx_vld}, 32'h0);
        chk("midrst_rx_rdy", {31'h0, fifo_rx_rdy}, 32'h1);
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_ack", {31'h0, mgmt_ack}, 32'h0);
        rd("postrst_stat", A_STAT, 32'h000A_0000);
        rd("postrst_ctrl", A_CTRL, 32'h0);

        // Miss address never acknowledged.
        bus(1'b1, A_MISS, 32'h0, 2'b00);
        chk("miss_ack0", {31'h0, r_ack}, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("miss_ack%0d", i), {30'h0, mgmt_ack, mgmt_rxe}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
